// File: rtl/downmix_pkg.sv
// Shared widths, derived constants and output saturation for the NCO I/Q down-mixer.
package downmix_pkg;

    localparam int unsigned IN_W         = 14;
    localparam int unsigned NCO_W        = 14;
    localparam int unsigned OUT_W        = 16;
    localparam int unsigned DEC_LOG2_MAX = 8;
    localparam int unsigned DEC_W        = 4;
    localparam int unsigned SH_W         = 5;
    localparam int unsigned CNT_W        = DEC_LOG2_MAX;
    localparam int unsigned PROD_W       = IN_W + NCO_W;
    localparam int unsigned ACC_W        = PROD_W + DEC_LOG2_MAX;
    localparam int unsigned SHIFT        = IN_W + NCO_W - OUT_W - 1;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    // Arithmetic right shift (floor) then clamp into the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] acc,
                                                        input logic [SH_W-1:0] shift);
        logic signed [ACC_W-1:0] m;
        logic signed [OUT_W-1:0] r;
        m = acc >>> shift;
        if (m > SAT_HI)
            r = SAT_HI[OUT_W-1:0];
        else if (m < SAT_LO)
            r = SAT_LO[OUT_W-1:0];
        else
            r = m[OUT_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/iq_integrate_dump.sv
// Integrate-and-dump for one mixer rail; DOWNMIX_ROUND_EN selects round-half-up over floor.
module iq_integrate_dump
    import downmix_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clken,
    input  logic                     prod_v,
    input  logic                     dump,
    input  logic [DEC_W-1:0]         sh,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [OUT_W-1:0]  out
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] rnd_c;
    logic [SH_W-1:0]         tot_sh_c;

    assign tot_sh_c = SH_W'(sh) + SH_W'(SHIFT);
    assign sum_c    = acc + ACC_W'(prod);

`ifdef DOWNMIX_ROUND_EN
    assign rnd_c = ACC_W'(1) << (tot_sh_c - SH_W'(1));
`else
    assign rnd_c = '0;
`endif

    // The dumping product is part of the emitted sum; the next window starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            out <= '0;
        end else if (clken && prod_v) begin
            if (dump) begin
                acc <= '0;
                out <= sat_out(sum_c + rnd_c, tot_sh_c);
            end else begin
                acc <= sum_c;
            end
        end
    end

endmodule

// File: rtl/nco_iq_downmix.sv
// Quadrature down-mixer: x*cos / -x*sin, integrate-and-dump over 2^dec_log2 samples.
// Optional build macro DOWNMIX_ROUND_EN (rounding inside iq_integrate_dump).
module nco_iq_downmix
    import downmix_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic signed [IN_W-1:0]  adc_i,
    input  logic                    adc_valid,
    input  logic                    nco_valid,
    input  logic signed [NCO_W-1:0] fsin_i,
    input  logic signed [NCO_W-1:0] fcos_i,
    input  logic [DEC_W-1:0]        dec_log2,
    output logic signed [OUT_W-1:0] i_o,
    output logic signed [OUT_W-1:0] q_o,
    output logic                    out_valid,
    output logic                    drop_o
);

    logic                     accept_c;
    logic [DEC_W-1:0]         dec_clamp_c;
    logic [DEC_W-1:0]         win_sh_c;
    logic                     win_last_c;
    logic [CNT_W-1:0]         count;
    logic [DEC_W-1:0]         shadow_dec;

    logic                     s1_v;
    logic                     s1_dump;
    logic [DEC_W-1:0]         s1_sh;
    logic signed [IN_W-1:0]   s1_x;
    logic signed [NCO_W-1:0]  s1_sin;
    logic signed [NCO_W-1:0]  s1_cos;

    logic signed [PROD_W-1:0] prod_i_c;
    logic signed [PROD_W-1:0] prod_q_c;

    logic                     s2_v;
    logic                     s2_dump;
    logic [DEC_W-1:0]         s2_sh;
    logic signed [PROD_W-1:0] s2_prod_i;
    logic signed [PROD_W-1:0] s2_prod_q;

    assign accept_c    = clken & adc_valid & nco_valid;
    assign dec_clamp_c = (dec_log2 > DEC_W'(DEC_LOG2_MAX)) ? DEC_W'(DEC_LOG2_MAX) : dec_log2;
    // A window's exponent is latched by its first sample; later dec_log2 changes wait.
    assign win_sh_c    = (count == '0) ? dec_clamp_c : shadow_dec;
    assign win_last_c  = count == CNT_W'((9'd1 << win_sh_c) - 9'd1);

    assign prod_i_c = PROD_W'(s1_x) * PROD_W'(s1_cos);
    assign prod_q_c = -(PROD_W'(s1_x) * PROD_W'(s1_sin));

    // Sample capture, window counter and multiplier pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            shadow_dec <= '0;
            drop_o     <= 1'b0;
            s1_v       <= 1'b0;
            s1_dump    <= 1'b0;
            s1_sh      <= '0;
            s1_x       <= '0;
            s1_sin     <= '0;
            s1_cos     <= '0;
            s2_v       <= 1'b0;
            s2_dump    <= 1'b0;
            s2_sh      <= '0;
            s2_prod_i  <= '0;
            s2_prod_q  <= '0;
        end else if (clken) begin
            s1_v <= accept_c;
            if (accept_c) begin
                s1_x    <= adc_i;
                s1_sin  <= fsin_i;
                s1_cos  <= fcos_i;
                s1_dump <= win_last_c;
                s1_sh   <= win_sh_c;
                count   <= win_last_c ? '0 : count + CNT_W'(1);
                if (count == '0)
                    shadow_dec <= dec_clamp_c;
            end
            if (adc_valid && !nco_valid)
                drop_o <= 1'b1;
            s2_v      <= s1_v;
            s2_dump   <= s1_dump;
            s2_sh     <= s1_sh;
            s2_prod_i <= prod_i_c;
            s2_prod_q <= prod_q_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_valid <= 1'b0;
        else
            out_valid <= clken & s2_v & s2_dump;
    end

    iq_integrate_dump u_int_i (
        .clk    (clk),
        .reset  (reset),
        .clken  (clken),
        .prod_v (s2_v),
        .dump   (s2_dump),
        .sh     (s2_sh),
        .prod   (s2_prod_i),
        .out    (i_o)
    );

    iq_integrate_dump u_int_q (
        .clk    (clk),
        .reset  (reset),
        .clken  (clken),
        .prod_v (s2_v),
        .dump   (s2_dump),
        .sh     (s2_sh),
        .prod   (s2_prod_q),
        .out    (q_o)
    );

endmodule

// File: tb/tb_nco_iq_downmix.sv
// Scoreboard bench for nco_iq_downmix; expected I/Q and arrival cycle queued by the driver.
module tb_nco_iq_downmix;
    import downmix_pkg::*;

    typedef struct {
        int exp_i;
        int exp_q;
        int exp_cyc;
    } exp_t;

`ifdef DOWNMIX_ROUND_EN
    localparam int EXP_3999 = 4000;
`else
    localparam int EXP_3999 = 3999;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    clken;
    logic signed [IN_W-1:0]  adc_i;
    logic                    adc_valid;
    logic                    nco_valid;
    logic signed [NCO_W-1:0] fsin_i;
    logic signed [NCO_W-1:0] fcos_i;
    logic [DEC_W-1:0]        dec_log2;
    logic signed [OUT_W-1:0] i_o;
    logic signed [OUT_W-1:0] q_o;
    logic                    out_valid;
    logic                    drop_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    nco_iq_downmix dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .adc_i     (adc_i),
        .adc_valid (adc_valid),
        .nco_valid (nco_valid),
        .fsin_i    (fsin_i),
        .fcos_i    (fcos_i),
        .dec_log2  (dec_log2),
        .i_o       (i_o),
        .q_o       (q_o),
        .out_valid (out_valid),
        .drop_o    (drop_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d i=%0d q=%0d", cyc, i_o, q_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("i_o", int'(i_o), e.exp_i);
                chk("q_o", int'(q_o), e.exp_q);
                chk("pulse_cycle", cyc, e.exp_cyc);
            end
        end
    end

    task automatic step(input logic ce, input logic av, input logic nv,
                        input int x, input int c, input int s);
        clken     = ce;
        adc_valid = av;
        nco_valid = nv;
        adc_i     = IN_W'(x);
        fcos_i    = NCO_W'(c);
        fsin_i    = NCO_W'(s);
        @(negedge clk);
    endtask

    task automatic push(input int ei, input int eq, input int lat);
        exp_t e;
        e.exp_i   = ei;
        e.exp_q   = eq;
        e.exp_cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b1, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        clken = 1'b1; adc_valid = 1'b0; nco_valid = 1'b0;
        adc_i = '0; fsin_i = '0; fcos_i = '0; dec_log2 = '0;
        repeat (2) @(negedge clk);
        chk("reset_i", int'(i_o), 0);
        chk("reset_q", int'(q_o), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_drop", int'(drop_o), 0);
        reset = 1'b0;
        @(negedge clk);

        // dec=0: pure mixer, one pulse per sample
        for (int k = 0; k < 4; k++) begin
            push(16382, 0, 3);
            step(1'b1, 1'b1, 1'b1, 4096, 8191, 0);
        end
        idle(4);

        // saturation at positive full scale
        for (int k = 0; k < 2; k++) begin
            push(32767, 0, 3);
            step(1'b1, 1'b1, 1'b1, -8192, -8192, 0);
        end
        idle(4);

        // dec=2, with dec_log2 changed mid-window (ignored until the next window)
        dec_log2 = 4'd2;
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        dec_log2 = 4'd0;
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        push(EXP_3999, -2000, 3);
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        idle(4);

        // dropped samples mid-window leave the window unchanged
        dec_log2 = 4'd2;
        chk("drop_before", int'(drop_o), 0);
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, -7000, 5000, -3000);
        chk("drop_set", int'(drop_o), 1);
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        push(EXP_3999, -2000, 3);
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        idle(4);
        chk("drop_sticky", int'(drop_o), 1);

        // clken low for 5 cycles while the last sample is in flight
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        push(EXP_3999, -2000, 8);
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 3000, 3000, 3000);
        idle(5);

        // dec_log2 above max clamps to a 256-sample window
        dec_log2 = 4'd15;
        for (int k = 0; k < 255; k++) step(1'b1, 1'b1, 1'b1, 4096, 8191, 0);
        push(16382, 0, 3);
        step(1'b1, 1'b1, 1'b1, 4096, 8191, 0);
        idle(4);

        // reset after 2 of 4 samples, dec_log2 changed to 1 during reset
        dec_log2 = 4'd2;
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        #2 reset = 1'b1;
        dec_log2 = 4'd1;
        adc_valid = 1'b0;
        #1;
        chk("rst_mid_i", int'(i_o), 0);
        chk("rst_mid_q", int'(q_o), 0);
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_drop", int'(drop_o), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);
        push(EXP_3999, -2000, 3);
        step(1'b1, 1'b1, 1'b1, 1000, 8191, 4096);

        // bounded drain of outstanding expectations
        for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
        idle(2);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
